// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - write port, launch control and skewed operand streams of the feeder
interface systolic_feeder_if #(
    parameter int DW = 8
);
    logic          wr_en;
    logic          wr_sel;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          start;
    logic          busy;
    logic          done;
    logic          acc_clr;
    logic          feed_valid;
    logic [DW-1:0] west0;
    logic [DW-1:0] west1;
    logic [DW-1:0] west2;
    logic [DW-1:0] west3;
    logic [DW-1:0] north0;
    logic [DW-1:0] north1;
    logic [DW-1:0] north2;
    logic [DW-1:0] north3;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  wr_ready, busy, done, acc_clr, feed_valid,
        input  west0, west1, west2, west3,
        input  north0, north1, north2, north3
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output wr_ready, busy, done, acc_clr, feed_valid,
        output west0, west1, west2, west3,
        output north0, north1, north2, north3
    );
endinterface

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - A/B operand buffers and diagonal skew sequencer for a 4x4 systolic array
module systolic_feeder #(
    parameter int DW = 8
) (
    input  logic clk,
    input  logic rst_n,
    systolic_feeder_if.slave s
);
    localparam int N = 4;
    localparam logic [3:0] FEED_LAST  = 4'(3 * N - 3);
    localparam logic [3:0] DRAIN_LAST = 4'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    t_q, t_d;
    logic [DW-1:0] a_q [N*N];
    logic [DW-1:0] a_d [N*N];
    logic [DW-1:0] b_q [N*N];
    logic [DW-1:0] b_d [N*N];

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          acc_clr_q, acc_clr_d;
    logic          feed_valid_q, feed_valid_d;
    logic          wr_ready_q, wr_ready_d;
    logic [DW-1:0] west_q [N];
    logic [DW-1:0] west_d [N];
    logic [DW-1:0] north_q [N];
    logic [DW-1:0] north_d [N];

    // t counts FEED steps, then is reused to time the DRAIN window.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                if (s.start) begin
                    state_d = S_CLEAR;
                    t_d     = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
            end
            S_FEED: begin
                if (t_q == FEED_LAST) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (t_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    // wr_ready_q is high exactly while the FSM sits in IDLE.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (s.wr_en && wr_ready_q) begin
            if (s.wr_sel) begin
                b_d[s.wr_addr] = s.wr_data;
            end else begin
                a_d[s.wr_addr] = s.wr_data;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with it after the edge.
    always_comb begin
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        acc_clr_d    = (state_d == S_CLEAR);
        feed_valid_d = (state_d == S_FEED);
        wr_ready_d   = (state_d == S_IDLE);
        for (int i = 0; i < N; i++) begin
            west_d[i]  = '0;
            north_d[i] = '0;
            if (state_d == S_FEED) begin
                if ((t_d >= 4'(i)) && ((t_d - 4'(i)) <= 4'd3)) begin
                    west_d[i]  = a_q[{2'(i), 2'(t_d - 4'(i))}];
                    north_d[i] = b_q[{2'(t_d - 4'(i)), 2'(i)}];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            acc_clr_q    <= 1'b0;
            feed_valid_q <= 1'b0;
            wr_ready_q   <= 1'b1;
            for (int i = 0; i < N * N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                west_q[i]  <= '0;
                north_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            acc_clr_q    <= acc_clr_d;
            feed_valid_q <= feed_valid_d;
            wr_ready_q   <= wr_ready_d;
            for (int i = 0; i < N * N; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
            for (int i = 0; i < N; i++) begin
                west_q[i]  <= west_d[i];
                north_q[i] <= north_d[i];
            end
        end
    end

    assign s.wr_ready   = wr_ready_q;
    assign s.busy       = busy_q;
    assign s.done       = done_q;
    assign s.acc_clr    = acc_clr_q;
    assign s.feed_valid = feed_valid_q;
    assign s.west0      = west_q[0];
    assign s.west1      = west_q[1];
    assign s.west2      = west_q[2];
    assign s.west3      = west_q[3];
    assign s.north0     = north_q[0];
    assign s.north1     = north_q[1];
    assign s.north2     = north_q[2];
    assign s.north3     = north_q[3];
endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - randomized run-level checks of systolic_feeder against a matrix/schedule model
module tb_systolic_feeder;
    logic clk = 1'b0;
    logic rst_n;

    systolic_feeder_if #(.DW(8)) bus ();

    systolic_feeder #(.DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int run_id  = 0;
    logic [7:0] ma [16];
    logic [7:0] mb [16];
    time  last_done = 0;
    bit   prev_hold = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cycle c counts from the launch edge: 1 = clear, 2..11 = feed, 12..15 = drain, 16 = done.
    function automatic logic [4:0] exp_flags(input int c);
        if (c == 1)                 return 5'b10100;
        else if (c >= 2 && c <= 11) return 5'b10010;
        else if (c >= 12 && c <= 15) return 5'b10000;
        else if (c == 16)           return 5'b11000;
        else                        return 5'b00001;
    endfunction

    function automatic logic [31:0] exp_west(input int c);
        logic [31:0] r = '0;
        int t = c - 2;
        if (c >= 2 && c <= 11)
            for (int i = 0; i < 4; i++)
                if (t - i >= 0 && t - i <= 3) r[8*i +: 8] = ma[4*i + (t - i)];
        return r;
    endfunction

    function automatic logic [31:0] exp_north(input int c);
        logic [31:0] r = '0;
        int t = c - 2;
        if (c >= 2 && c <= 11)
            for (int j = 0; j < 4; j++)
                if (t - j >= 0 && t - j <= 3) r[8*j +: 8] = mb[4*(t - j) + j];
        return r;
    endfunction

    function automatic logic [4:0] got_flags();
        return {bus.busy, bus.done, bus.acc_clr, bus.feed_valid, bus.wr_ready};
    endfunction

    task automatic check_cycle(input int c);
        chk_eq($sformatf("run%0d c%0d flags", run_id, c), 32'(got_flags()), 32'(exp_flags(c)));
        chk_eq($sformatf("run%0d c%0d west", run_id, c),
               {bus.west3, bus.west2, bus.west1, bus.west0}, exp_west(c));
        chk_eq($sformatf("run%0d c%0d north", run_id, c),
               {bus.north3, bus.north2, bus.north1, bus.north0}, exp_north(c));
    endtask

    task automatic wr(input bit sel, input logic [3:0] addr, input logic [7:0] data);
        bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_addr = addr; bus.wr_data = data;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        if (sel) mb[addr] = data; else ma[addr] = data;
    endtask

    // hold: 0 = single pulse, 1 = keep start high, 2 = keep high then drop before the idle edge.
    task automatic run(input int hold, input int wr_at, input int start_at, input int rst_at,
                       input bit wr_with_start, input logic [3:0] wa, input logic [7:0] wd);
        int last;
        time t_done;
        run_id++;
        last = (hold == 1) ? 17 : 18;
        bus.start = 1'b1;
        if (wr_with_start) begin
            bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = wa; bus.wr_data = wd;
            ma[wa] = wd;
        end
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        if (hold == 0) bus.start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            check_cycle(c);
            if (c == 16) begin
                t_done = $time;
                if (hold != 0 && prev_hold)
                    chk_eq($sformatf("run%0d done_period", run_id), 32'(t_done - last_done), 32'd170);
                last_done = t_done;
            end
            if (c == wr_at) begin
                bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 8'hFF;
            end
            if (c == wr_at + 1) bus.wr_en = 1'b0;
            if (c == start_at) bus.start = 1'b1;
            if (c == start_at + 1) bus.start = 1'b0;
            if (hold == 2 && c == 17) bus.start = 1'b0;
            if (c == rst_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int k = 0; k < 16; k++) begin
                    ma[k] = '0; mb[k] = '0;
                end
                check_cycle(17);
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    chk_eq($sformatf("run%0d abort idle%0d", run_id, k), 32'(got_flags()), 32'(exp_flags(17)));
                end
                prev_hold = 0;
                return;
            end
        end
        prev_hold = (hold == 1);
    endtask

    task automatic rand_fill();
        for (int k = 0; k < 16; k++) begin
            wr(1'b0, 4'(k), 8'($urandom));
            wr(1'b1, 4'(k), 8'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 8'h5A;
        bus.start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ma[k] = '0; mb[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; bus.wr_en = 1'b0; bus.start = 1'b0;
        check_cycle(17);

        run(0, -1, -1, -1, 1'b0, 4'd0, 8'd0);

        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                wr(1'b0, 4'(4*i + k), 8'(4*i + k + 1));
                wr(1'b1, 4'(4*i + k), (i == k) ? 8'd1 : 8'd0);
            end
        run(0, -1, -1, -1, 1'b0, 4'd0, 8'd0);

        repeat (2) begin
            rand_fill();
            run(0, -1, -1, -1, 1'b0, 4'd0, 8'd0);
        end

        run(0, 4, -1, -1, 1'b0, 4'd0, 8'd0);
        run(0, -1, -1, -1, 1'b1, 4'd5, 8'($urandom));
        run(0, -1, 13, -1, 1'b0, 4'd0, 8'd0);

        rand_fill();
        run(1, -1, -1, -1, 1'b0, 4'd0, 8'd0);
        run(1, -1, -1, -1, 1'b0, 4'd0, 8'd0);
        run(2, -1, -1, -1, 1'b0, 4'd0, 8'd0);

        run(0, -1, -1, 7, 1'b0, 4'd0, 8'd0);
        run(0, -1, -1, -1, 1'b0, 4'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input sequencer for the 4x4 weight/activation systolic array: the transmitting end of the array's west/north operand interface. Matrices A and B (4x4, 8-bit elements) are written into internal buffers, then on `start` the block emits the diagonally skewed streams the array consumes: row i of A on west port i, column j of B on north port j. It also emits a one-cycle accumulator clear before the streams, and a `done` pulse once the last operand pair has had time to reach PE(3,3).

## Interface
- `DW`, default 8, operand element width.
- `N`, fixed 4, array dimension. Ports are enumerated per row/column, so N is not a free parameter.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  buffer write strobe.
- `wr_sel`  in  1  target buffer: 0 = A, 1 = B.
- `wr_addr`  in  4  element index, row*4+col.
- `wr_data`  in  DW  element value.
- `wr_ready`  out  1  high when writes are accepted (state IDLE).
- `start`  in  1  launch request; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `acc_clr`  out  1  one-cycle clear to array accumulators.
- `feed_valid`  out  1  high while streams carry schedule data (FEED).
- `west0..west3`  out  DW each  skewed A rows, to array west inputs 0/4/8/12.
- `north0..north3`  out  DW each  skewed B columns, to array north inputs 0..3.

## Operation
- Buffers: A[4][4] and B[4][4] registers. A write commits at the edge when `wr_en && wr_ready`; writes outside IDLE are dropped silently.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
  - IDLE -> CLEAR when `start`=1; otherwise stays in IDLE.
  - CLEAR lasts 1 cycle, with `acc_clr`=1. Then -> FEED.
  - FEED lasts 10 cycles (3N-2). Step counter t = 0..9. Then -> DRAIN.
  - DRAIN lasts 4 cycles (N). All streams 0. Then -> DONE.
  - DONE lasts 1 cycle, with `done`=1. Then -> IDLE.
- Skew schedule during FEED step t:
  - `west_i` = A[i][t-i] if 0 <= t-i <= 3, else 0.
  - `north_j` = B[t-j][j] if 0 <= t-j <= 3, else 0.
- Outside FEED, all `west`/`north` outputs are 0.
- All outputs are registered and driven as decoded functions of state/t (no combinational path from `start` or `wr_*`).
- `start` arriving outside IDLE is ignored (not queued).
- Buffers are never modified by a run, so repeated `start` pulses replay the same matrices.
- Write and `start` in the same IDLE cycle: the write commits and is included in the run.

## Timing
- Reset (`rst_n`=0 at an edge): next cycle state=IDLE, t=0, all buffer entries 0. Outputs after reset: `busy`=0, `done`=0, `acc_clr`=0, `feed_valid`=0, `wr_ready`=1, all streams 0.
- Reset mid-run: same result, and abandons the run with no `done`.
- `start` sampled at edge k gives:
  - cycle k+1: CLEAR, `busy`=1, `wr_ready`=0, `acc_clr`=1.
  - cycles k+2..k+11: FEED, `feed_valid`=1, step t = cycle-(k+2).
  - cycles k+12..k+15: DRAIN.
  - cycle k+16: DONE, `done`=1, `busy`=1.
  - cycle k+17: IDLE, `busy`=0, `wr_ready`=1. A new `start` may be sampled at the end of k+17.
- Run length is 16 busy cycles; back-to-back launch period is 17 cycles.
- Last nonzero operands: `west3`=A[3][3] and `north3`=B[3][3] at t=6. With 1-cycle PE forwarding they reach PE(3,3) at t=9. DRAIN covers result settling.
- Counter: 4-bit, wraps never (bounded by state); t is reset to 0 on entry to FEED.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `wr_en`=1 and `start`=1 -> all outputs at reset values, buffers read back as zero (run yields all-zero streams), `wr_ready`=1.
- Skew pattern: A[i][k]=4i+k+1, B=identity, `start` at edge k. Required streams:
  - t=0: `west0`=1, other west ports 0; `north0`=1.
  - t=1: `west0`=2, `west1`=5; `north1`=0.
  - t=3: `west3`=13, `north3`=0.
  - t=6: `west3`=16, `north3`=1.
  - t=7..9: all streams 0.
  - `done` at k+16.
- Full multiply: feeder driving the systolic array, random signed-agnostic 8-bit A and B -> array results equal A x B (32-bit) when `done`=1.
- Dropped writes: write A[0][0]=0xFF during FEED -> ignored. Next run shows the old A[0][0] on `west0` at t=0.
- Start handling:
  - `start` held high continuously -> runs separated by exactly one IDLE cycle, `done` every 17 cycles.
  - `start` pulse during DRAIN -> ignored.
- Reset at FEED t=5 -> next cycle IDLE, streams 0, no `done`. Buffers zeroed, so a following run streams zeros.
